// File: rtl/project_pkg.sv
// Shared types and constants for the SRAM-to-UART dump path.
// Holds the dump FSM state enum and UART frame geometry.
package project_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_CAPTURE,
    S_SEND_HI,
    S_SEND_LO,
    S_DONE
  } dump_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake.
// Ports: clk, rst_n, tx_valid, tx_data[7:0] in; tx_ready, tx_o out.
module uart_tx_byte
  import project_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  logic [CW-1:0]           clk_cnt;
  logic [3:0]              bit_idx;
  logic [UART_DATA_BITS:0] sh;
  logic                    active;
  logic                    bit_end;
  logic                    last_bit;
  logic                    take;

  assign bit_end  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_idx == 4'(UART_FRAME_BITS - 1));
  // Ready in the final stop-bit cycle lets frames abut.
  assign tx_ready = !active || (bit_end && last_bit);
  assign take     = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      sh      <= '1;
      tx_o    <= 1'b1;
    end else if (take) begin
      active  <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      sh      <= {1'b1, tx_data};
      tx_o    <= 1'b0;
    end else if (active) begin
      if (!bit_end) begin
        clk_cnt <= clk_cnt + CW'(1);
      end else if (last_bit) begin
        active  <= 1'b0;
        clk_cnt <= '0;
        tx_o    <= 1'b1;
      end else begin
        clk_cnt <= '0;
        bit_idx <= bit_idx + 4'd1;
        tx_o    <= sh[0];
        sh      <= {1'b1, sh[UART_DATA_BITS:1]};
      end
    end
  end

endmodule

// File: rtl/sram_uart_dump.sv
// Streams a range of 16-bit SRAM words out over UART, high byte first.
// Ports: Clock, Resetn, Start, Start_address, Word_count, SRAM_read_data in;
//        SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done out.
module sram_uart_dump
  import project_pkg::*;
#(
  parameter int CLOCK_FREQ   = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLOCK_FREQ / BAUD
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  dump_state_t state, state_n;

  logic [17:0] cnt;
  logic [7:0]  lo_buf;
  logic [15:0] pf_word;
  logic [2:0]  fetch_pipe;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        hi_take;
  logic        lo_take;
  logic        more;

  assign SRAM_we_n = 1'b1;
  assign Busy      = (state != S_IDLE) && (state != S_DONE);
  assign Done      = (state == S_DONE);
  assign more      = (cnt != 18'd1);
  assign hi_take   = tx_valid && tx_ready &&
                     (state == S_CAPTURE || state == S_SEND_HI);
  assign lo_take   = tx_valid && tx_ready && (state == S_SEND_LO);

  always_comb begin
    state_n  = state;
    tx_valid = 1'b0;
    tx_data  = lo_buf;
    unique case (state)
      S_IDLE: begin
        if (Start)
          state_n = (Word_count == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: state_n = S_WAIT;
      S_WAIT:  state_n = S_CAPTURE;
      // First high byte goes straight from the bus so its start
      // bit lands the cycle after capture.
      S_CAPTURE: begin
        tx_valid = 1'b1;
        tx_data  = SRAM_read_data[15:8];
        if (tx_ready) state_n = S_SEND_LO;
      end
      S_SEND_HI: begin
        tx_valid = 1'b1;
        tx_data  = pf_word[15:8];
        if (tx_ready) state_n = S_SEND_LO;
      end
      // cnt reaching 0 means the last low byte is in flight;
      // linger until its stop bit ends.
      S_SEND_LO: begin
        if (cnt != '0) begin
          tx_valid = 1'b1;
          if (tx_ready && more) state_n = S_SEND_HI;
        end else if (tx_ready) begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_IDLE;
      SRAM_address <= '0;
      cnt          <= '0;
      lo_buf       <= '0;
      pf_word      <= '0;
      fetch_pipe   <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && Start) begin
        cnt <= Word_count;
        if (Word_count != '0) SRAM_address <= Start_address;
      end
      if (hi_take)
        lo_buf <= (state == S_CAPTURE) ? SRAM_read_data[7:0]
                                       : pf_word[7:0];
      if (lo_take) begin
        cnt <= cnt - 18'd1;
        if (more) SRAM_address <= SRAM_address + 18'd1;
      end
      // Tracks the 2-cycle read latency of the prefetch.
      fetch_pipe <= {fetch_pipe[1:0], lo_take && more};
      if (fetch_pipe[2]) pf_word <= SRAM_read_data;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (Clock),
    .rst_n   (Resetn),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx_o    (UART_TX_O)
  );

endmodule

// File: tb/tb_sram_uart_dump.sv
// Self-checking bench for sram_uart_dump.
// Waveform model plus directed literal checks.
module tb_sram_uart_dump;

  localparam int C = 4;
  localparam int DB = 434;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        Resetn;
  logic        Start;
  logic [17:0] Start_address;
  logic [17:0] Word_count;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  logic        start_d;
  logic [17:0] addr_d;
  logic [17:0] cnt_d;
  logic [17:0] sram_addr_d;
  logic        we_d;
  logic [15:0] rd_d;
  logic        tx_d;
  logic        busy_d;
  logic        done_d;

  logic [15:0] mem [0:262143];

  logic [15:0] rd1, rd2, drd1, drd2;
  always @(posedge clk) begin
    rd1  <= mem[SRAM_address];
    rd2  <= rd1;
    drd1 <= mem[sram_addr_d];
    drd2 <= drd1;
  end
  assign SRAM_read_data = rd2;
  assign rd_d = drd2;

  sram_uart_dump #(.CLKS_PER_BIT(C)) dut (
    .Clock         (clk),
    .Resetn        (Resetn),
    .Start         (Start),
    .Start_address (Start_address),
    .Word_count    (Word_count),
    .SRAM_address  (SRAM_address),
    .SRAM_we_n     (SRAM_we_n),
    .SRAM_read_data(SRAM_read_data),
    .UART_TX_O     (UART_TX_O),
    .Busy          (Busy),
    .Done          (Done)
  );

  sram_uart_dump dut_dflt (
    .Clock         (clk),
    .Resetn        (Resetn),
    .Start         (start_d),
    .Start_address (addr_d),
    .Word_count    (cnt_d),
    .SRAM_address  (sram_addr_d),
    .SRAM_we_n     (we_d),
    .SRAM_read_data(rd_d),
    .UART_TX_O     (tx_d),
    .Busy          (busy_d),
    .Done          (done_d)
  );

  bit          m_on = 1'b0;
  int          m_t0 = 0;
  logic [17:0] m_addr = '0;
  int          m_n = 0;

  task automatic chk(input string nm, input logic [47:0] got,
                     input logic [47:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, got, want, cyc);
    end
  endtask

  function automatic int t_end();
    return 4 + 20 * m_n * C;
  endfunction

  function automatic logic exp_tx(input int k);
    int b, f, pos;
    logic [17:0] a;
    logic [15:0] w;
    logic [7:0]  byt;
    if (!m_on || m_n == 0) return 1'b1;
    if (k < 4 || k >= t_end()) return 1'b1;
    b   = (k - 4) / C;
    f   = b / 10;
    pos = b % 10;
    a   = m_addr + 18'(f / 2);
    w   = mem[a];
    byt = (f % 2 == 0) ? w[15:8] : w[7:0];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return byt[pos-1];
  endfunction

  function automatic logic exp_busy(input int k);
    return m_on && m_n != 0 && k >= 1 && k < t_end();
  endfunction

  function automatic logic exp_done(input int k);
    return m_on && k == ((m_n == 0) ? 1 : t_end());
  endfunction

  always @(negedge clk) begin : cmp
    int k;
    k = cyc - m_t0;
    chk("we_n", 48'(SRAM_we_n), 48'd1);
    chk("tx", 48'(UART_TX_O), 48'(exp_tx(k)));
    chk("busy", 48'(Busy), 48'(exp_busy(k)));
    chk("done", 48'(Done), 48'(exp_done(k)));
    if (m_on && m_n != 0 && k == 1)
      chk("addr", 48'(SRAM_address), 48'(m_addr));
  end

  bit   arm = 1'b0;
  logic prev_d = 1'b1;
  int   dq[$];
  always @(negedge clk) begin
    if (arm && tx_d !== prev_d) dq.push_back(cyc);
    prev_d = tx_d;
  end

  task automatic wait_cycle(input int tgt);
    while (cyc < tgt) @(negedge clk);
  endtask

  task automatic do_start(input logic [17:0] a, input logic [17:0] n);
    @(posedge clk); #1;
    Start = 1'b1;
    Start_address = a;
    Word_count = n;
    m_on = 1'b1;
    m_t0 = cyc;
    m_addr = a;
    m_n = int'(n);
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit,
                           input int want);
    int  k;
    bit  seen;
    seen = 1'b0;
    k = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (Done) begin
        seen = 1'b1;
        k = cyc - m_t0;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: Done not seen in %0d cycles, want cycle %0d",
               nm, limit, want);
    end else begin
      chk(nm, 48'(k), 48'(want));
    end
  endtask

  task automatic get_bytes(input int t0, input int nb,
                           output logic [47:0] data);
    logic [7:0] byt;
    data = '0;
    byt = '0;
    for (int f = 0; f < nb; f++) begin
      for (int i = 0; i < 8; i++) begin
        wait_cycle(t0 + 4 + (f * 10 + 1 + i) * C + 2);
        byt[i] = UART_TX_O;
      end
      data = {data[39:0], byt};
    end
  endtask

  initial begin
    logic [19:0] bits;
    logic [47:0] got;
    logic [17:0] prev;
    int          t0d;
    int          kd;
    bit          seen;

    Resetn = 1'b1;
    Start = 1'b0;
    Start_address = '0;
    Word_count = '0;
    start_d = 1'b0;
    addr_d = '0;
    cnt_d = '0;
    mem[18'h00010] = 16'hA55A;
    mem[18'h00100] = 16'h0102;
    mem[18'h00101] = 16'h0304;
    mem[18'h00102] = 16'h0506;
    mem[18'h3FFFF] = 16'hBEEF;
    mem[18'h00000] = 16'h1234;
    mem[18'h00200] = 16'h0F0F;
    mem[18'h00003] = 16'hFFFF;

    #1 Resetn = 1'b0;
    #2;
    chk("rst_addr", 48'(SRAM_address), 48'd0);
    chk("rst_we_n", 48'(SRAM_we_n), 48'd1);
    chk("rst_tx", 48'(UART_TX_O), 48'd1);
    chk("rst_busy", 48'(Busy), 48'd0);
    chk("rst_done", 48'(Done), 48'd0);
    chk("rst_tx_dflt", 48'(tx_d), 48'd1);
    repeat (3) @(posedge clk);
    #1 Resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Single word 0xA55A
    do_start(18'h00010, 18'd1);
    bits = '0;
    for (int b = 0; b < 20; b++) begin
      wait_cycle(m_t0 + 4 + b * C + 2);
      bits = {bits[18:0], UART_TX_O};
    end
    chk("single_bits", 48'(bits), 48'(20'b01010010110010110101));
    wait_done("single_done", 20, 84);
    repeat (3) @(posedge clk);

    // Zero count
    prev = SRAM_address;
    do_start(18'h00123, 18'd0);
    wait_done("zero_done", 5, 1);
    chk("zero_addr", 48'(SRAM_address), 48'(prev));
    repeat (3) @(posedge clk);

    // Back-to-back words
    do_start(18'h00100, 18'd3);
    get_bytes(m_t0, 6, got);
    chk("b2b_bytes", got, 48'h010203040506);
    wait_done("b2b_done", 20, 244);
    repeat (3) @(posedge clk);

    // Address wrap
    do_start(18'h3FFFF, 18'd2);
    get_bytes(m_t0, 4, got);
    chk("wrap_bytes", got, 48'h0000BEEF1234);
    wait_done("wrap_done", 20, 164);
    repeat (3) @(posedge clk);

    // Ignored start, then reset mid-frame
    do_start(18'h00200, 18'd1);
    wait_cycle(m_t0 + 10);
    Start = 1'b1;
    Start_address = 18'h00003;
    Word_count = 18'd7;
    @(negedge clk);
    Start = 1'b0;
    wait_cycle(m_t0 + 25);
    @(posedge clk); #1;
    m_on = 1'b0;
    Resetn = 1'b0;
    #1;
    chk("rst_mid_tx", 48'(UART_TX_O), 48'd1);
    chk("rst_mid_busy", 48'(Busy), 48'd0);
    repeat (3) @(posedge clk);
    #1 Resetn = 1'b1;
    repeat (2) @(posedge clk);
    do_start(18'h00200, 18'd1);
    get_bytes(m_t0, 2, got);
    chk("after_rst_bytes", got, 48'h00000000_0F0F);
    wait_done("after_rst_done", 20, 84);
    repeat (3) @(posedge clk);

    // Default bit rate
    @(posedge clk); #1;
    start_d = 1'b1;
    addr_d = 18'h00010;
    cnt_d = 18'd1;
    t0d = cyc;
    arm = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    seen = 1'b0;
    kd = -1;
    for (int i = 0; i < 9000 && !seen; i++) begin
      @(negedge clk);
      if (cyc - t0d == 100)
        chk("dflt_busy", 48'(busy_d), 48'd1);
      if (done_d) begin
        seen = 1'b1;
        kd = cyc - t0d;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL dflt_done: Done not seen, want cycle %0d",
               4 + 20 * DB);
    end else begin
      chk("dflt_done", 48'(kd), 48'(4 + 20 * DB));
    end
    chk("dflt_we_n", 48'(we_d), 48'd1);
    if (dq.size() < 9) begin
      checks++;
      errors++;
      $display("FAIL dflt_edges: got %0d edges want at least 9",
               dq.size());
    end else begin
      chk("dflt_start", 48'(dq[0] - t0d), 48'd4);
      chk("dflt_bit0", 48'(dq[1] - dq[0]), 48'(DB));
      chk("dflt_bit1", 48'(dq[2] - dq[1]), 48'(DB));
      chk("dflt_frame", 48'(dq[8] - dq[0]), 48'(10 * DB));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
